// File: rtl/usiq_byte_packer.sv
// Packs 24-bit IQ samples from a showahead FIFO into an MSB-first byte stream, in bursts of BURST samples.
// Optional macro USIQ_SYNC_EN prefixes every burst with three 0x7F sync bytes.
module usiq_byte_packer #(
  parameter int unsigned BURST = 63
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] us_tdata,
  input  logic        us_tvalid,
  output logic        us_tready,
  input  logic        us_tlast,
  input  logic [1:0]  us_tuser,
  input  logic [10:0] us_tlength,
  output logic [7:0]  tx_tdata,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  output logic        tx_tlast,
  output logic [1:0]  tx_tuser
);

  localparam int unsigned CLOG = $clog2(BURST + 1);
  localparam int unsigned CW   = (CLOG < 6) ? 6 : CLOG;

`ifdef USIQ_SYNC_EN
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_LOAD, S_B2, S_B1, S_B0} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_B2, S_B1, S_B0} state_t;
`endif

  state_t          state_q, state_d;
  logic [23:0]     samp_q, samp_d;
  logic [1:0]      user_q, user_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
`ifdef USIQ_SYNC_EN
  logic [1:0]      sync_q, sync_d;
`endif

  assign cnt_inc = cnt_q + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      samp_q  <= '0;
      user_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef USIQ_SYNC_EN
      sync_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      user_q  <= user_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
`ifdef USIQ_SYNC_EN
      sync_q  <= sync_d;
`endif
    end
  end

  // Byte outputs decode directly from registered state and captured sample,
  // so the async reset clears them in the same cycle.
  always_comb begin
    state_d   = state_q;
    samp_d    = samp_q;
    user_d    = user_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
`ifdef USIQ_SYNC_EN
    sync_d    = sync_q;
`endif
    us_tready = 1'b0;
    tx_tdata  = '0;
    tx_tvalid = 1'b0;
    tx_tlast  = 1'b0;
    tx_tuser  = '0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (us_tlength >= 11'(BURST)) begin
`ifdef USIQ_SYNC_EN
          sync_d  = '0;
          state_d = S_SYNC;
`else
          state_d = S_LOAD;
`endif
        end
      end
`ifdef USIQ_SYNC_EN
      S_SYNC: begin
        tx_tvalid = 1'b1;
        tx_tdata  = 8'h7F;
        if (tx_tready) begin
          if (sync_q == 2'd2) state_d = S_LOAD;
          else                sync_d  = sync_q + 2'd1;
        end
      end
`endif
      S_LOAD: begin
        us_tready = us_tvalid;
        if (us_tvalid) begin
          samp_d  = us_tdata;
          user_d  = us_tuser;
          cnt_d   = cnt_inc;
          last_d  = us_tlast || (cnt_inc >= CW'(BURST));
          state_d = S_B2;
        end
      end
      S_B2: begin
        tx_tvalid = 1'b1;
        tx_tdata  = samp_q[23:16];
        tx_tuser  = user_q;
        if (tx_tready) state_d = S_B1;
      end
      S_B1: begin
        tx_tvalid = 1'b1;
        tx_tdata  = samp_q[15:8];
        tx_tuser  = user_q;
        if (tx_tready) state_d = S_B0;
      end
      S_B0: begin
        tx_tvalid = 1'b1;
        tx_tdata  = samp_q[7:0];
        tx_tuser  = user_q;
        tx_tlast  = last_q;
        if (tx_tready) begin
          if (last_q) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_usiq_byte_packer.sv
// Bench for usiq_byte_packer: FIFO model feeds samples, expected byte stream is derived from the sample list.
module tb_usiq_byte_packer;

  localparam int unsigned BURST = 4;
`ifdef USIQ_SYNC_EN
  localparam int OFF = 3;
  localparam int LAT = 1;
`else
  localparam int OFF = 0;
  localparam int LAT = 2;
`endif

  typedef struct packed {logic [23:0] d; logic [1:0] u; logic l;} samp_t;
  typedef struct packed {logic [7:0] d; logic [1:0] u; logic l;} byte_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] us_tdata = '0;
  logic        us_tvalid = 1'b0;
  logic        us_tready;
  logic        us_tlast = 1'b0;
  logic [1:0]  us_tuser = '0;
  logic [10:0] us_tlength = '0;
  logic [7:0]  tx_tdata;
  logic        tx_tvalid;
  logic        tx_tready = 1'b0;
  logic        tx_tlast;
  logic [1:0]  tx_tuser;

  usiq_byte_packer #(.BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .us_tdata(us_tdata), .us_tvalid(us_tvalid), .us_tready(us_tready),
    .us_tlast(us_tlast), .us_tuser(us_tuser), .us_tlength(us_tlength),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .tx_tlast(tx_tlast), .tx_tuser(tx_tuser)
  );

  always #5 clk = ~clk;

  int    tests = 0;
  int    fails = 0;
  samp_t fifo[$];
  byte_t exp_q[$];
  byte_t obs[$];
  int    seg = 0;
  int    pops = 0;
  bit    rst_req = 1'b1;
  bit    lie = 1'b0;
  logic [10:0] lie_val = '0;
  int    rdy_mode = 0;
  bit    tgl = 1'b1;
  bit    hold_pend = 1'b0;
  byte_t hold_b;
  bit    saw_val, saw_rdy;

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Expected bytes follow from the sample sequence alone: a burst closes at BURST samples or tlast.
  task automatic append_model(samp_t s);
    bit endb;
    seg++;
    endb = (seg == int'(BURST)) || s.l;
    if (seg == 1) for (int i = 0; i < OFF; i++) exp_q.push_back('{d: 8'h7F, u: 2'b00, l: 1'b0});
    exp_q.push_back('{d: s.d[23:16], u: s.u, l: 1'b0});
    exp_q.push_back('{d: s.d[15:8],  u: s.u, l: 1'b0});
    exp_q.push_back('{d: s.d[7:0],   u: s.u, l: endb});
    if (endb) seg = 0;
  endtask

  task automatic rebuild();
    exp_q.delete();
    seg = 0;
    foreach (fifo[i]) append_model(fifo[i]);
  endtask

  task automatic push(logic [23:0] d, logic [1:0] u, logic l);
    samp_t s;
    s = '{d: d, u: u, l: l};
    fifo.push_back(s);
    append_model(s);
  endtask

  task automatic step();
    @(negedge clk);
    rst_n     = !rst_req;
    us_tvalid = (fifo.size() != 0);
    if (us_tvalid) {us_tdata, us_tuser, us_tlast} = {fifo[0].d, fifo[0].u, fifo[0].l};
    else           {us_tdata, us_tuser, us_tlast} = '0;
    us_tlength = lie ? lie_val : 11'(fifo.size());
    case (rdy_mode)
      0:       tx_tready = 1'b1;
      1:       begin tx_tready = tgl; tgl = !tgl; end
      default: tx_tready = ($urandom_range(0, 3) != 0);
    endcase
    #1;
    if (!rst_n) begin
      chk("reset_outputs", 32'({tx_tdata, tx_tvalid, tx_tlast, tx_tuser, us_tready}), 32'd0);
      rebuild();
      hold_pend = 1'b0;
    end else begin
      if (us_tready) saw_rdy = 1'b1;
      if (tx_tvalid) saw_val = 1'b1;
      chk("us_tready_gating", 32'(us_tready && (!us_tvalid || tx_tvalid)), 32'd0);
      if (hold_pend)
        chk("byte_hold", 32'({tx_tvalid, tx_tdata, tx_tuser, tx_tlast}), 32'({1'b1, hold_b}));
      if (tx_tvalid && tx_tready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL byte_stream: got unexpected byte 0x%0h, expected no byte", tx_tdata);
        end else begin
          chk("byte_stream", 32'({tx_tdata, tx_tuser, tx_tlast}), 32'(exp_q.pop_front()));
        end
        obs.push_back('{d: tx_tdata, u: tx_tuser, l: tx_tlast});
      end
      if (us_tvalid && us_tready) begin
        void'(fifo.pop_front());
        pops++;
      end
      hold_pend = tx_tvalid && !tx_tready;
      hold_b    = '{d: tx_tdata, u: tx_tuser, l: tx_tlast};
    end
  endtask

  task automatic run_until(int n, int budget, string name);
    int k = 0;
    while (obs.size() < n && k < budget) begin step(); k++; end
    chk(name, obs.size(), n);
  endtask

  task automatic chk_sync_prefix(string name);
    for (int i = 0; i < OFF; i++) chk(name, 32'(obs[i]), 32'({8'h7F, 2'b00, 1'b0}));
  endtask

  logic [7:0] l31 [12] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC,
                           8'hDE, 8'hF0, 8'h12, 8'h34, 8'h56, 8'h78};

  task automatic chk_l31(string name);
    chk_sync_prefix({name, "_sync"});
    for (int i = 0; i < 12; i++)
      chk(name, 32'({obs[OFF+i].d, obs[OFF+i].l}), 32'({l31[i], i == 11}));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset
    rst_req = 1'b1; rdy_mode = 0;
    step(); step();
    rst_req = 1'b0;
    step();
    chk("post_reset_idle", 32'({tx_tvalid, us_tready}), 32'd0);

    // below threshold: nothing happens
    obs.delete(); saw_val = 0; saw_rdy = 0;
    push(24'h123456, 2'b00, 1'b0);
    push(24'h789ABC, 2'b00, 1'b0);
    push(24'hDEF012, 2'b00, 1'b0);
    for (int i = 0; i < 30; i++) step();
    chk("below_thr_valid", 32'(saw_val), 32'd0);
    chk("below_thr_ready", 32'(saw_rdy), 32'd0);

    // threshold reached: latency then the 12-byte burst
    pops = 0;
    push(24'h345678, 2'b00, 1'b0);
    step();
    n = 0;
    while (!tx_tvalid && n < 10) begin step(); n++; end
    chk("first_byte_latency", n, LAT);
    run_until(12 + OFF, 200, "burst_len");
    chk("burst_pops", pops, 4);
    chk_l31("burst_bytes");

    // backpressure 1010
    obs.delete(); pops = 0; rdy_mode = 1; tgl = 1'b1;
    push(24'h123456, 2'b00, 1'b0);
    push(24'h789ABC, 2'b00, 1'b0);
    push(24'hDEF012, 2'b00, 1'b0);
    push(24'h345678, 2'b00, 1'b0);
    run_until(12 + OFF, 400, "bp_len");
    chk("bp_pops", pops, 4);
    chk_l31("bp_bytes");

    // reset during B1 of sample 2
    obs.delete(); rdy_mode = 0;
    push(24'hA1A2A3, 2'b00, 1'b0);
    push(24'hB1B2B3, 2'b00, 1'b0);
    push(24'hC1C2C3, 2'b00, 1'b0);
    push(24'hD1D2D3, 2'b00, 1'b0);
    run_until(4 + OFF, 200, "pre_reset_len");
    rst_req = 1'b1; step();
    rst_req = 1'b0; step();
    chk("reset_drops_sample", fifo.size(), 2);
    obs.delete();
    push(24'hE1E2E3, 2'b00, 1'b0);
    push(24'hF1F2F3, 2'b00, 1'b0);
    run_until(12 + OFF, 200, "post_reset_len");
    chk_sync_prefix("post_reset_sync");
    chk("post_reset_first", 32'(obs[OFF]), 32'({8'hC1, 2'b00, 1'b0}));
    chk("post_reset_last", 32'(obs[OFF+11]), 32'({8'hF3, 2'b00, 1'b1}));

    // tlast on sample 2
    obs.delete();
    push(24'h010203, 2'b00, 1'b0);
    push(24'h040506, 2'b10, 1'b1);
    push(24'h070809, 2'b01, 1'b0);
    push(24'h0A0B0C, 2'b00, 1'b0);
    run_until(6 + OFF, 200, "tlast_len");
    for (int i = 0; i < 20; i++) step();
    chk("tlast_no_extra", obs.size(), 6 + OFF);
    chk_sync_prefix("tlast_sync");
    chk("tlast_b1", 32'(obs[OFF+0]), 32'({8'h01, 2'b00, 1'b0}));
    chk("tlast_b2", 32'(obs[OFF+1]), 32'({8'h02, 2'b00, 1'b0}));
    chk("tlast_b3", 32'(obs[OFF+2]), 32'({8'h03, 2'b00, 1'b0}));
    chk("tlast_b4", 32'(obs[OFF+3]), 32'({8'h04, 2'b10, 1'b0}));
    chk("tlast_b5", 32'(obs[OFF+4]), 32'({8'h05, 2'b10, 1'b0}));
    chk("tlast_b6", 32'(obs[OFF+5]), 32'({8'h06, 2'b10, 1'b1}));

    // random traffic with backpressure, tlength lies and occasional resets
    rdy_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0 && fifo.size() < 40)
        push(24'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 49) == 0) begin
        lie = !lie;
        lie_val = 11'($urandom);
      end
      rst_req = ($urandom_range(0, 699) == 0);
      step();
    end
    rst_req = 1'b0;
    step();

    // drain: claim a full FIFO so every pending sample gets emitted
    lie = 1'b1; lie_val = 11'h7FF;
    while (seg != 0) push(24'($urandom), 2'($urandom), 1'b0);
    n = 0;
    while ((exp_q.size() != 0 || fifo.size() != 0) && n < 4000) begin step(); n++; end
    chk("drain_complete", exp_q.size() + fifo.size(), 0);
    lie = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("idle_after_drain", 32'(tx_tvalid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
